chimp_grid_datapath: RTL and testbench
======================================

Name: chimp_grid_datapath

Overview:
Parametrised datapath for the chimp memory test, and the successor to the fixed 8x8 board datapath. It supports a configurable square grid and number width, and owns the full round sequence: clear, random placement with collision retry, and ordered click checking. After the first correct click, all remaining numbers are masked. The block sits between the chimp control FSM, which supplies iStart and iLevel, the LFSR, which supplies iRandNum, the mouse/box decoder, and the VGA renderer, which scans the cell read port.

Parameters:
GRID_DIM, 8, grid side length; the board has GRID_DIM*GRID_DIM cells.
COORD_W, 3, coordinate width; must equal $clog2(GRID_DIM).
NUM_W, 5, width of the cell number, level and counters.

Ports:
clk  in  1  system clock
iReset  in  1  asynchronous active-high reset
iStart  in  1  one-cycle pulse: begin a new round, accepted in any state
iLevel  in  NUM_W  numbers to place; sampled only on iStart
iRandNum  in  2*COORD_W  random cell index {x,y}; new value every cycle
iMouseClick  in  1  one-cycle click pulse
iBoxX, iBoxY  in  COORD_W each  clicked cell
iRdX, iRdY  in  COORD_W each  renderer read address
oRdNum  out  NUM_W  number stored at the read cell (combinational)
oRdUsed  out  1  read cell holds a number
oRdVisible  out  1  read cell is used, not cleared, and the board is not masked
oRdCleared  out  1  read cell already correctly clicked
oBusy  out  1  high in CLEAR and LOAD
oDoneLoad  out  1  high in PLAY
oChoseCorrectNum  out  1  one-cycle pulse
oChoseWrongNum  out  1  one-cycle pulse
oRoundWon  out  1  one-cycle pulse
oNextNum  out  NUM_W  next number expected
oRoundCounter  out  NUM_W  numbers placed so far

Behaviour:
- Per-cell state is {used, cleared, num[NUM_W-1:0]}. There is also a global mask flag and a latched level register, lvl.
- Reset (asynchronous, any time, including mid-load or mid-play):
  - all cells, lvl, mask, counters and pulses go to 0;
  - the state goes to IDLE;
  - oNextNum = 1.
- States are IDLE, CLEAR, LOAD, PLAY and DONE. iStart in any state forces CLEAR on the next cycle and restarts the round.
- CLEAR (1 cycle):
  - every cell is zeroed, mask=0, oRoundCounter=0, oNextNum=1;
  - lvl = iLevel, with iLevel=0 treated as 1 and iLevel > GRID_DIM^2 clamped to GRID_DIM^2;
  - next state is LOAD.
- LOAD (one placement attempt per cycle):
  - The candidate is x=iRandNum[2*COORD_W-1:COORD_W], y=iRandNum[COORD_W-1:0].
  - If x<GRID_DIM, y<GRID_DIM and the cell is unused: num <= oRoundCounter+1, used <= 1, oRoundCounter++.
  - If the candidate is occupied or out of range, nothing is written and the block retries the next cycle. There is no timeout.
  - When oRoundCounter reaches lvl (compared on the registered value), the next state is PLAY. oDoneLoad rises one cycle after the final placement.
- PLAY: iMouseClick is sampled at the clock edge. The click is ignored if the clicked cell is unused, already cleared, or out of range. Otherwise:
  - num == oNextNum: oChoseCorrectNum pulses the following cycle, cleared <= 1, mask <= 1, oNextNum++. If oNextNum == lvl at the time of the click, oRoundWon also pulses the same cycle and the next state is DONE.
  - num != oNextNum: oChoseWrongNum pulses, the next state is DONE, and the board stays intact for the reveal.
- DONE: oRdVisible = used && !cleared regardless of mask, so the renderer reveals the answers. Clicks are ignored. The block stays in DONE until iStart.
- Clicks in IDLE, CLEAR and LOAD are ignored and are not queued.
- If iStart and iMouseClick arrive in the same cycle, iStart wins and no pulse is produced.
- Pulses are registered, last exactly one cycle, and are mutually exclusive except for correct+won.
- The read port is purely combinational from the registered cells. oRdVisible = used && !cleared && (!mask || state==DONE).
- oRoundCounter and oNextNum never wrap, because lvl is clamped to GRID_DIM^2 <= 2^NUM_W - 1. A parameter set that violates this is illegal and must raise an elaboration assertion.

Test Plan:
- Reset mid-LOAD with iLevel=5, asserted after 3 placements: all outputs 0 immediately (asynchronously); oNextNum=1; oRdUsed=0 for every cell; IDLE until iStart.
- iLevel=4 with iRandNum forced to {3,3},{3,3},{1,2},{7,7},{0,0},{1,2},{5,6}: cells (3,3)=1, (1,2)=2, (7,7)=3, (0,0)=4; (5,6) stays unused; the repeated candidates are retried and not written; oDoneLoad rises after the fourth placement.
- From that board, click (3,3), (1,2), (7,7), (0,0) in order: three oChoseCorrectNum pulses, then correct+oRoundWon together on the fourth click. oRdVisible is 0 everywhere after the first click. The state is DONE.
- Same board, click (3,3) then (0,0): one correct pulse, then oChoseWrongNum. In DONE, (1,2), (7,7) and (0,0) read visible and (3,3) reads not visible.
- Clicks on (5,6) (empty), on (3,3) again (already cleared), and during LOAD: no pulses, oNextNum unchanged.
- GRID_DIM=4, COORD_W=2, NUM_W=5, iLevel=31: lvl clamps to 16; all 16 cells are filled; oRoundCounter=16. Then iStart together with a click in PLAY: the round restarts and no pulse is produced.

Source files
------------

// File: rtl/chimp_grid_datapath.sv
// chimp_grid_datapath: board storage, placement and click checking
// for the chimp memory test on a GRID_DIM x GRID_DIM grid.
module chimp_grid_datapath #(
  parameter int GRID_DIM = 8,
  parameter int COORD_W  = 3,
  parameter int NUM_W    = 5
) (
  input  logic                 clk,
  input  logic                 iReset,
  input  logic                 iStart,
  input  logic [NUM_W-1:0]     iLevel,
  input  logic [2*COORD_W-1:0] iRandNum,
  input  logic                 iMouseClick,
  input  logic [COORD_W-1:0]   iBoxX,
  input  logic [COORD_W-1:0]   iBoxY,
  input  logic [COORD_W-1:0]   iRdX,
  input  logic [COORD_W-1:0]   iRdY,
  output logic [NUM_W-1:0]     oRdNum,
  output logic                 oRdUsed,
  output logic                 oRdVisible,
  output logic                 oRdCleared,
  output logic                 oBusy,
  output logic                 oDoneLoad,
  output logic                 oChoseCorrectNum,
  output logic                 oChoseWrongNum,
  output logic                 oRoundWon,
  output logic [NUM_W-1:0]     oNextNum,
  output logic [NUM_W-1:0]     oRoundCounter
);

  localparam int CELLS = GRID_DIM * GRID_DIM;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  // Counters must not wrap at the largest clamped level.
  if (COORD_W != $clog2(GRID_DIM) ||
      CELLS > (2 ** NUM_W) - 1) begin : gBadParams
    $error("chimp_grid_datapath: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    PLAY,
    DONE
  } stateT;

  stateT state;
  stateT stateNext;

  logic             cellUsed    [CELLS];
  logic             cellCleared [CELLS];
  logic [NUM_W-1:0] cellNum     [CELLS];

  logic [NUM_W-1:0] lvl;
  logic             mask;

  function automatic logic inGrid(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y
  );
    return (int'(x) < GRID_DIM) && (int'(y) < GRID_DIM);
  endfunction

  // Out-of-grid coordinates map to cell 0 so reads stay in bounds;
  // callers qualify the result with inGrid.
  function automatic logic [IDX_W-1:0] cellIdx(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y
  );
    if (!inGrid(x, y)) return '0;
    return IDX_W'(int'(y) * GRID_DIM + int'(x));
  endfunction

  logic [COORD_W-1:0] candX;
  logic [COORD_W-1:0] candY;
  logic [IDX_W-1:0]   candIdx;
  logic [IDX_W-1:0]   boxIdx;
  logic [IDX_W-1:0]   rdIdx;
  logic               rdOk;
  logic               place;
  logic               loadDone;
  logic               clickHit;
  logic               clickMatch;
  logic               lastNum;
  logic [NUM_W-1:0]   levelClamped;

  assign candX   = iRandNum[2*COORD_W-1:COORD_W];
  assign candY   = iRandNum[COORD_W-1:0];
  assign candIdx = cellIdx(candX, candY);
  assign boxIdx  = cellIdx(iBoxX, iBoxY);
  assign rdIdx   = cellIdx(iRdX, iRdY);
  assign rdOk    = inGrid(iRdX, iRdY);

  assign loadDone = (state == LOAD) &&
                    (oRoundCounter == lvl);

  assign place = !iStart && (state == LOAD) &&
                 (oRoundCounter != lvl) &&
                 inGrid(candX, candY) &&
                 !cellUsed[candIdx];

  assign clickHit = iMouseClick && !iStart &&
                    (state == PLAY) &&
                    inGrid(iBoxX, iBoxY) &&
                    cellUsed[boxIdx] &&
                    !cellCleared[boxIdx];

  assign clickMatch = cellNum[boxIdx] == oNextNum;
  assign lastNum    = oNextNum == lvl;

  // Level of zero means one number; above the cell count it saturates.
  always_comb begin
    levelClamped = iLevel;
    if (iLevel == '0)
      levelClamped = NUM_W'(1);
    else if (int'(iLevel) > CELLS)
      levelClamped = NUM_W'(CELLS);
  end

  // Round sequencing: iStart overrides everything.
  always_comb begin
    stateNext = state;
    unique case (1'b1)
      iStart:
        stateNext = CLEAR;
      !iStart && (state == CLEAR):
        stateNext = LOAD;
      !iStart && loadDone:
        stateNext = PLAY;
      clickHit && (!clickMatch || lastNum):
        stateNext = DONE;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) state <= IDLE;
    else        state <= stateNext;
  end

  // Board, counters and registered result pulses.
  always_ff @(posedge clk or posedge iReset) begin
    if (iReset) begin
      for (int i = 0; i < CELLS; i++) begin
        cellUsed[i]    <= 1'b0;
        cellCleared[i] <= 1'b0;
        cellNum[i]     <= '0;
      end
      lvl              <= '0;
      mask             <= 1'b0;
      oRoundCounter    <= '0;
      oNextNum         <= NUM_W'(1);
      oChoseCorrectNum <= 1'b0;
      oChoseWrongNum   <= 1'b0;
      oRoundWon        <= 1'b0;
    end else begin
      oChoseCorrectNum <= clickHit && clickMatch;
      oChoseWrongNum   <= clickHit && !clickMatch;
      oRoundWon        <= clickHit && clickMatch && lastNum;
      if (iStart) lvl <= levelClamped;
      if (state == CLEAR) begin
        for (int i = 0; i < CELLS; i++) begin
          cellUsed[i]    <= 1'b0;
          cellCleared[i] <= 1'b0;
          cellNum[i]     <= '0;
        end
        mask          <= 1'b0;
        oRoundCounter <= '0;
        oNextNum      <= NUM_W'(1);
      end
      if (place) begin
        cellUsed[candIdx] <= 1'b1;
        cellNum[candIdx]  <= oRoundCounter + NUM_W'(1);
        oRoundCounter     <= oRoundCounter + NUM_W'(1);
      end
      if (clickHit && clickMatch) begin
        cellCleared[boxIdx] <= 1'b1;
        mask                <= 1'b1;
        oNextNum            <= oNextNum + NUM_W'(1);
      end
    end
  end

  // Renderer read port and status flags.
  always_comb begin
    oRdUsed    = rdOk && cellUsed[rdIdx];
    oRdCleared = rdOk && cellCleared[rdIdx];
    oRdNum     = rdOk ? cellNum[rdIdx] : '0;
    oRdVisible = oRdUsed && !oRdCleared &&
                 (!mask || (state == DONE));
    oBusy      = (state == CLEAR) || (state == LOAD);
    oDoneLoad  = (state == PLAY);
  end

endmodule

// File: tb/tb_chimp_grid_datapath.sv
// tb_chimp_grid_datapath: directed rounds on an 8x8 and a 4x4 board,
// checked every cycle against a placement-queue model of the game.
`timescale 1ns/1ps
module tb_chimp_grid_datapath;

  logic clk = 1'b0;
  always #100 clk = ~clk;

  logic       rst;
  logic       start, click;
  logic [4:0] level;
  logic [5:0] randN;
  logic [2:0] boxX, boxY, rdX, rdY;
  logic [4:0] rdNum, nextNum, roundCnt;
  logic       rdUsed, rdVis, rdClr, busy, doneLoad;
  logic       correct, wrong, won;

  logic       start4, click4;
  logic [4:0] level4;
  logic [3:0] rand4;
  logic [1:0] box4X, box4Y, rd4X, rd4Y;
  logic [4:0] rdNum4, nextNum4, roundCnt4;
  logic       rdUsed4, rdVis4, rdClr4, busy4, doneLoad4;
  logic       correct4, wrong4, won4;

  chimp_grid_datapath #(
    .GRID_DIM(8), .COORD_W(3), .NUM_W(5)
  ) dut8 (
    .clk(clk), .iReset(rst), .iStart(start),
    .iLevel(level), .iRandNum(randN),
    .iMouseClick(click), .iBoxX(boxX), .iBoxY(boxY),
    .iRdX(rdX), .iRdY(rdY), .oRdNum(rdNum),
    .oRdUsed(rdUsed), .oRdVisible(rdVis),
    .oRdCleared(rdClr), .oBusy(busy),
    .oDoneLoad(doneLoad), .oChoseCorrectNum(correct),
    .oChoseWrongNum(wrong), .oRoundWon(won),
    .oNextNum(nextNum), .oRoundCounter(roundCnt)
  );

  chimp_grid_datapath #(
    .GRID_DIM(4), .COORD_W(2), .NUM_W(5)
  ) dut4 (
    .clk(clk), .iReset(rst), .iStart(start4),
    .iLevel(level4), .iRandNum(rand4),
    .iMouseClick(click4), .iBoxX(box4X), .iBoxY(box4Y),
    .iRdX(rd4X), .iRdY(rd4Y), .oRdNum(rdNum4),
    .oRdUsed(rdUsed4), .oRdVisible(rdVis4),
    .oRdCleared(rdClr4), .oBusy(busy4),
    .oDoneLoad(doneLoad4), .oChoseCorrectNum(correct4),
    .oChoseWrongNum(wrong4), .oRoundWon(won4),
    .oNextNum(nextNum4), .oRoundCounter(roundCnt4)
  );

  int errors = 0;
  int checks = 0;

  // Game model: phase 0 idle, 1 clear, 2 load, 3 play, 4 done.
  // mQ lists cell indices (y*8+x) in placement order, so the number
  // in a cell is its queue position + 1; mHits numbers are cleared.
  int mPhase, mLvl, mHits;
  int mQ[$];
  bit mC, mW, mWon;

  function automatic int posOf(input int idx);
    foreach (mQ[i]) if (mQ[i] == idx) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int idx, p;
    if (rst) begin
      mPhase = 0; mLvl = 0; mHits = 0;
      mQ.delete();
      mC = 0; mW = 0; mWon = 0;
    end else begin
      mC = 0; mW = 0; mWon = 0;
      if (start) begin
        mPhase = 1;
        mLvl = (level == 0) ? 1 :
               (int'(level) > 64 ? 64 : int'(level));
      end else begin
        case (mPhase)
          1: begin
            mQ.delete(); mHits = 0; mPhase = 2;
          end
          2: begin
            if (mQ.size() == mLvl) mPhase = 3;
            else begin
              idx = int'(randN[2:0]) * 8 + int'(randN[5:3]);
              if (posOf(idx) < 0) mQ.push_back(idx);
            end
          end
          3: if (click) begin
            p = posOf(int'(boxY) * 8 + int'(boxX));
            if (p >= mHits) begin
              if (p == mHits) begin
                mC = 1; mHits++;
                if (mHits == mLvl) begin
                  mWon = 1; mPhase = 4;
                end
              end else begin
                mW = 1; mPhase = 4;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic compareAll();
    int p;
    chk("roundCounter", int'(roundCnt), mQ.size());
    chk("nextNum", int'(nextNum), mHits + 1);
    chk("busy", int'(busy), int'(mPhase == 1 || mPhase == 2));
    chk("doneLoad", int'(doneLoad), int'(mPhase == 3));
    chk("correct", int'(correct), int'(mC));
    chk("wrong", int'(wrong), int'(mW));
    chk("won", int'(won), int'(mWon));
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        rdX = 3'(x); rdY = 3'(y);
        #1;
        p = posOf(y * 8 + x);
        chk($sformatf("rdUsed(%0d,%0d)", x, y),
            int'(rdUsed), int'(p >= 0));
        chk($sformatf("rdNum(%0d,%0d)", x, y),
            int'(rdNum), (p >= 0) ? p + 1 : 0);
        chk($sformatf("rdCleared(%0d,%0d)", x, y),
            int'(rdClr), int'(p >= 0 && p < mHits));
        chk($sformatf("rdVisible(%0d,%0d)", x, y), int'(rdVis),
            int'(p >= mHits && (mHits == 0 || mPhase == 4)));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compareAll();
    @(posedge clk);
    #10;
  endtask

  task automatic readCell(input int x, input int y);
    rdX = 3'(x); rdY = 3'(y);
    #1;
  endtask

  task automatic clickAt(input int x, input int y);
    click = 1'b1; boxX = 3'(x); boxY = 3'(y);
    step();
    click = 1'b0;
  endtask

  task automatic loadBoard(input bit withClick);
    int seq[7] = '{27, 27, 10, 63, 0, 10, 46};
    level = 5'd4; start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      randN = 6'(seq[i]);
      if (withClick && i == 3) begin
        click = 1'b1; boxX = 3'd3; boxY = 3'd3;
      end
      step();
      click = 1'b0;
      if (withClick && i == 3) begin
        chk("load click correct", int'(correct), 0);
        chk("load click wrong", int'(wrong), 0);
        chk("load click nextNum", int'(nextNum), 1);
      end
      if (i == 4) begin
        chk("load rc4", int'(roundCnt), 4);
        chk("load doneLoad early", int'(doneLoad), 0);
      end
      if (i == 5) chk("load doneLoad", int'(doneLoad), 1);
    end
    readCell(3, 3); chk("num(3,3)", int'(rdNum), 1);
    readCell(1, 2); chk("num(1,2)", int'(rdNum), 2);
    readCell(7, 7); chk("num(7,7)", int'(rdNum), 3);
    readCell(0, 0); chk("num(0,0)", int'(rdNum), 4);
    readCell(5, 6); chk("used(5,6)", int'(rdUsed), 0);
    chk("model order", mQ[1], 17);
  endtask

  initial begin
    rst = 1'b1;
    start = 0; click = 0; level = '0; randN = '0;
    boxX = '0; boxY = '0; rdX = '0; rdY = '0;
    start4 = 0; click4 = 0; level4 = '0; rand4 = '0;
    box4X = '0; box4Y = '0; rd4X = '0; rd4Y = '0;
    step();
    step();
    chk("reset nextNum", int'(nextNum), 1);
    chk("reset rc", int'(roundCnt), 0);
    rst = 1'b0;
    step();

    // Reset mid-load after three placements of level 5.
    level = 5'd5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    randN = 6'd27; step();
    randN = 6'd10; step();
    randN = 6'd63; step();
    chk("midload rc", int'(roundCnt), 3);
    chk("midload busy", int'(busy), 1);
    #10 rst = 1'b1;
    #1;
    chk("async rc", int'(roundCnt), 0);
    chk("async nextNum", int'(nextNum), 1);
    chk("async busy", int'(busy), 0);
    chk("async doneLoad", int'(doneLoad), 0);
    for (int i = 0; i < 64; i++) begin
      readCell(i % 8, i / 8);
      chk($sformatf("async used %0d", i), int'(rdUsed), 0);
    end
    #1 rst = 1'b0;
    step();
    step();
    chk("idle busy", int'(busy), 0);
    chk("idle doneLoad", int'(doneLoad), 0);

    // Full winning round, with a click ignored during load.
    loadBoard(1'b1);
    clickAt(3, 3);
    chk("c1 correct", int'(correct), 1);
    chk("c1 won", int'(won), 0);
    chk("c1 nextNum", int'(nextNum), 2);
    for (int i = 0; i < 64; i++) begin
      readCell(i % 8, i / 8);
      chk($sformatf("masked vis %0d", i), int'(rdVis), 0);
    end
    clickAt(1, 2);
    chk("c2 correct", int'(correct), 1);
    clickAt(7, 7);
    chk("c3 correct", int'(correct), 1);
    clickAt(0, 0);
    chk("c4 correct", int'(correct), 1);
    chk("c4 won", int'(won), 1);
    chk("c4 wrong", int'(wrong), 0);
    step();
    chk("won pulse len", int'(won), 0);
    chk("done doneLoad", int'(doneLoad), 0);
    chk("model done", mPhase, 4);

    // Ignored clicks, then a wrong click and the reveal.
    loadBoard(1'b0);
    clickAt(5, 6);
    chk("empty correct", int'(correct), 0);
    chk("empty wrong", int'(wrong), 0);
    chk("empty nextNum", int'(nextNum), 1);
    clickAt(3, 3);
    chk("w1 correct", int'(correct), 1);
    clickAt(3, 3);
    chk("again correct", int'(correct), 0);
    chk("again wrong", int'(wrong), 0);
    chk("again nextNum", int'(nextNum), 2);
    clickAt(0, 0);
    chk("w2 wrong", int'(wrong), 1);
    chk("w2 correct", int'(correct), 0);
    chk("w2 won", int'(won), 0);
    readCell(1, 2); chk("reveal(1,2)", int'(rdVis), 1);
    readCell(7, 7); chk("reveal(7,7)", int'(rdVis), 1);
    readCell(0, 0); chk("reveal(0,0)", int'(rdVis), 1);
    readCell(3, 3); chk("reveal(3,3)", int'(rdVis), 0);
    clickAt(1, 2);
    chk("done click correct", int'(correct), 0);
    chk("done click wrong", int'(wrong), 0);

    // 4x4 board: level 31 clamps to 16 cells.
    level4 = 5'd31; start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    for (int r = 0; r < 16; r++) begin
      rand4 = 4'(r);
      step();
    end
    chk("g4 rc", int'(roundCnt4), 16);
    chk("g4 busy", int'(busy4), 1);
    step();
    chk("g4 doneLoad", int'(doneLoad4), 1);
    for (int r = 0; r < 16; r++) begin
      rd4X = 2'(r / 4); rd4Y = 2'(r % 4);
      #1;
      chk($sformatf("g4 used %0d", r), int'(rdUsed4), 1);
      chk($sformatf("g4 num %0d", r), int'(rdNum4), r + 1);
    end
    start4 = 1'b1; click4 = 1'b1;
    box4X = 2'd0; box4Y = 2'd0;
    step();
    start4 = 1'b0; click4 = 1'b0;
    chk("g4 restart correct", int'(correct4), 0);
    chk("g4 restart wrong", int'(wrong4), 0);
    chk("g4 restart won", int'(won4), 0);
    chk("g4 restart busy", int'(busy4), 1);
    step();
    chk("g4 cleared rc", int'(roundCnt4), 0);
    chk("g4 cleared nextNum", int'(nextNum4), 1);
    chk("g4 load doneLoad", int'(doneLoad4), 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
